// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM between two requesters.
// A tag pipeline matched to the ROM latency steers each returned word back to its issuer.
module rom_read_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int ROM_LAT = 1
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  // last_q names the port granted most recently (1 after reset, so port 0 wins the first tie)
  logic          last_q, last_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0] tag_vld_q, tag_vld_d;
  logic [ROM_LAT:0] tag_id_q, tag_id_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          gnt0_c, gnt1_c;
  logic          ret_vld, ret_id;

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || last_q)) begin
        gnt0_c = 1'b1;
      end else if (req1) begin
        gnt1_c = 1'b1;
      end
    end
  end

  always_comb begin
    last_d     = last_q;
    rom_addr_d = rom_addr_q;
    if (gnt0_c) begin
      last_d     = 1'b0;
      rom_addr_d = addr0;
    end else if (gnt1_c) begin
      last_d     = 1'b1;
      rom_addr_d = addr1;
    end

    tag_vld_d = {tag_vld_q[ROM_LAT-1:0], gnt0_c | gnt1_c};
    tag_id_d  = {tag_id_q[ROM_LAT-1:0], gnt1_c};

    // The oldest tag lines up with the word the ROM is presenting right now
    ret_vld   = tag_vld_q[ROM_LAT];
    ret_id    = tag_id_q[ROM_LAT];
    rvalid0_d = ret_vld & ~ret_id;
    rvalid1_d = ret_vld & ret_id;
    rdata0_d  = rvalid0_d ? rom_data : rdata0_q;
    rdata1_d  = rvalid1_d ? rom_data : rdata1_q;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      last_q     <= 1'b1;
      rom_addr_q <= '0;
      tag_vld_q  <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      last_q     <= last_d;
      rom_addr_q <= rom_addr_d;
      tag_vld_q  <= tag_vld_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Port ids are only meaningful alongside a set valid bit, so they carry no reset
  always_ff @(posedge sys_clk) begin
    tag_id_q <= tag_id_d;
  end

  assign gnt0     = gnt0_c;
  assign gnt1     = gnt1_c;
  assign rom_addr = rom_addr_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: directed scenarios plus randomized traffic,
// with a behavioural grant/return model and a ROM model returning addr + 8'h10.
module tb_rom_read_arbiter;

  localparam int AW     = 5;
  localparam int DW     = 8;
  localparam int TB_LAT = 1;

  localparam int IDLE  = 0;
  localparam int FIXED = 1;
  localparam int SWEEP = 2;
  localparam int RAND  = 3;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          sys_clk;
  logic          rst;
  logic          req_v [2];
  logic [AW-1:0] addr_v [2];
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] rom_pipe [TB_LAT];

  exp_t          q0[$];
  exp_t          q1[$];
  bit            got_gnt [2];
  int            model_last;
  logic [AW-1:0] model_rom_addr;
  logic [DW-1:0] model_rdata [2];
  int            cyc;
  int            total;
  int            bad;

  rom_read_arbiter #(.AW(AW), .DW(DW), .ROM_LAT(TB_LAT)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .req0     (req_v[0]),
    .addr0    (addr_v[0]),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .req1     (req_v[1]),
    .addr1    (addr_v[1]),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    rom_pipe[0] <= {3'b000, rom_addr} + 8'h10;
    for (int i = 1; i < TB_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[TB_LAT-1];

  initial cyc = 0;
  always @(posedge sys_clk) cyc++;

  function automatic void check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Grant model: whoever asks alone wins; on a tie the port not served last wins
  always @(negedge sys_clk) begin
    int   winner;
    exp_t e;
    if (rst) begin
      q0.delete();
      q1.delete();
      model_last     = 1;
      model_rom_addr = '0;
      check_output("gnt_in_reset", {gnt1, gnt0}, 0);
      check_output("rom_addr_in_reset", rom_addr, 0);
    end else begin
      winner = -1;
      if (req_v[0] && req_v[1]) winner = (model_last == 0) ? 1 : 0;
      else if (req_v[0])        winner = 0;
      else if (req_v[1])        winner = 1;
      check_output("gnt0", gnt0, (winner == 0) ? 1 : 0);
      check_output("gnt1", gnt1, (winner == 1) ? 1 : 0);
      check_output("rom_addr", rom_addr, model_rom_addr);
      if (winner >= 0) begin
        e.data = {3'b000, addr_v[winner]} + 8'h10;
        e.due  = cyc + TB_LAT + 2;
        if (winner == 0) q0.push_back(e);
        else             q1.push_back(e);
        model_rom_addr = addr_v[winner];
        model_last     = winner;
      end
    end
    got_gnt[0] = gnt0;
    got_gnt[1] = gnt1;
  end

  // Return monitor: each rvalid must match the oldest outstanding grant of that port
  always @(negedge sys_clk) begin
    logic          rv;
    logic [DW-1:0] rd;
    exp_t          e;
    int            qsize;
    for (int p = 0; p < 2; p++) begin
      rv = (p == 0) ? rvalid0 : rvalid1;
      rd = (p == 0) ? rdata0 : rdata1;
      qsize = (p == 0) ? q0.size() : q1.size();
      if (rst) begin
        check_output($sformatf("rvalid%0d_in_reset", p), rv, 0);
        check_output($sformatf("rdata%0d_in_reset", p), rd, 0);
        model_rdata[p] = '0;
      end else if (rv) begin
        if (qsize == 0) begin
          check_output($sformatf("rvalid%0d_unexpected", p), 1, 0);
        end else begin
          e = (p == 0) ? q0.pop_front() : q1.pop_front();
          check_output($sformatf("rdata%0d", p), rd, e.data);
          check_output($sformatf("latency%0d_due", p), cyc, e.due);
        end
        model_rdata[p] = rd;
      end else begin
        check_output($sformatf("rdata%0d_hold", p), rd, model_rdata[p]);
        if (qsize > 0) begin
          e = (p == 0) ? q0[0] : q1[0];
          if (e.due <= cyc) begin
            check_output($sformatf("rvalid%0d_late", p), 0, 1);
            if (p == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
      end
    end
  end

  task automatic update_port(input int p, input int mode);
    case (mode)
      FIXED: req_v[p] = 1'b1;
      SWEEP: begin
        if (req_v[p] && got_gnt[p]) addr_v[p] = addr_v[p] + 1'b1;
        req_v[p] = 1'b1;
      end
      RAND: begin
        if (!(req_v[p] && !got_gnt[p])) begin
          req_v[p]  = 1'($urandom_range(0, 1));
          addr_v[p] = AW'($urandom);
        end
      end
      default: req_v[p] = 1'b0;
    endcase
  endtask

  task automatic apply_stimulus(input int n, input int m0, input int m1);
    repeat (n) begin
      update_port(0, m0);
      update_port(1, m1);
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (n) @(posedge sys_clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    req_v[0]  = 1'b0;
    req_v[1]  = 1'b0;
    addr_v[0] = '0;
    addr_v[1] = '0;
    do_reset(3);

    addr_v[0] = 5'd5;
    apply_stimulus(1, FIXED, IDLE);
    apply_stimulus(6, IDLE, IDLE);

    do_reset(2);
    addr_v[0] = 5'd3;
    addr_v[1] = 5'd7;
    apply_stimulus(4, FIXED, FIXED);
    apply_stimulus(6, IDLE, IDLE);

    addr_v[1] = 5'd0;
    apply_stimulus(34, IDLE, SWEEP);
    apply_stimulus(6, IDLE, IDLE);

    addr_v[0] = 5'd12;
    addr_v[1] = 5'd12;
    apply_stimulus(3, FIXED, IDLE);
    apply_stimulus(4, FIXED, FIXED);
    apply_stimulus(6, IDLE, IDLE);

    addr_v[0] = 5'd9;
    apply_stimulus(1, FIXED, IDLE);
    req_v[0] = 1'b0;
    do_reset(2);
    addr_v[1] = 5'd2;
    apply_stimulus(1, IDLE, FIXED);
    apply_stimulus(6, IDLE, IDLE);

    apply_stimulus(300, RAND, RAND);
    apply_stimulus(100, SWEEP, RAND);
    apply_stimulus(100, RAND, SWEEP);
    apply_stimulus(10, IDLE, IDLE);

    check_output("scoreboard0_drained", q0.size(), 0);
    check_output("scoreboard1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
